sorcerer_cass_fsk: RTL

//  Cassette-out FSK modulator. Consumes the serial TX line of the cassette UART and produces
//  the tape signal: a square wave on CASS_OUT and a 14-bit level on AUDIO.

---
 rtl/sorcerer_cass_fsk_pkg.sv | 36 +++
 rtl/sorcerer_cass_fsk_if.sv | 39 +++
 rtl/sorcerer_cass_fsk_tone_gen.sv | 73 +++++++
 rtl/sorcerer_cass_fsk.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sorcerer_cass_fsk_pkg.sv
// ---------------------------------------------------------------------------
// sorcerer_cass_pkg
//   Shared types and constants for the Sorcerer cassette FSK modulator.
//   - cass_state_t : modulator FSM state (OFF / RUN)
//   - *_DEF        : default tone half-periods in CLK12 cycles and AUDIO level
//   - hp_sel()     : maps (baud select, tx bit) to a tone half-period
// ---------------------------------------------------------------------------
package sorcerer_cass_pkg;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } cass_state_t;

    // Half-periods at 12 MHz: 2400 Hz, 1200 Hz, 600 Hz.
    localparam logic [13:0] HP_2400_DEF = 14'd2500;
    localparam logic [13:0] HP_1200_DEF = 14'd5000;
    localparam logic [13:0] HP_600_DEF  = 14'd10000;
    localparam logic [13:0] AMPL_DEF    = 14'h0800;

    // 300 baud:  mark 2400 Hz, space 1200 Hz.
    // 1200 baud: mark 1200 Hz, space 600 Hz.
    function automatic logic [13:0] hp_sel(
        input logic        baud,
        input logic        tx_bit,
        input logic [13:0] hp_2400 = HP_2400_DEF,
        input logic [13:0] hp_1200 = HP_1200_DEF,
        input logic [13:0] hp_600  = HP_600_DEF
    );
        if (baud) begin
            return tx_bit ? hp_1200 : hp_600;
        end
        return tx_bit ? hp_2400 : hp_1200;
    endfunction

endpackage

// File: rtl/sorcerer_cass_fsk_if.sv
// ---------------------------------------------------------------------------
// sorcerer_cass_fsk_if
//   Signal bundle between the cassette UART / top level and the FSK modulator.
//   master : drives TX_BIT, BAUD_SEL, MOTOR; observes the modulator outputs
//   slave  : the modulator itself
//   Signals:
//     TX_BIT   1   UART serial level, 1=mark 0=space
//     BAUD_SEL 1   0=300 baud tones, 1=1200 baud tones
//     MOTOR    1   cassette motor relay, 0 forces silence
//     CASS_OUT 1   FSK square wave
//     AUDIO    14  unsigned audio level
//     CYC_END  1   one-clock strobe at each completed tone cycle
//     STATE    -   modulator FSM state (debug visibility)
//   There is no valid/ready handshake on this bundle: every input is a plain
//   level that the modulator samples on every CLK12 edge, and every output is
//   a registered level (CYC_END a registered one-clock pulse).
// ---------------------------------------------------------------------------
interface sorcerer_cass_fsk_if;
    import sorcerer_cass_pkg::*;

    logic        TX_BIT;
    logic        BAUD_SEL;
    logic        MOTOR;
    logic        CASS_OUT;
    logic [13:0] AUDIO;
    logic        CYC_END;
    cass_state_t STATE;

    modport master (
        output TX_BIT, BAUD_SEL, MOTOR,
        input  CASS_OUT, AUDIO, CYC_END, STATE
    );

    modport slave (
        input  TX_BIT, BAUD_SEL, MOTOR,
        output CASS_OUT, AUDIO, CYC_END, STATE
    );

endinterface

// File: rtl/sorcerer_cass_fsk_tone_gen.sv
// ---------------------------------------------------------------------------
// sorcerer_tone_gen
//   Half-period reload counter, CASS_OUT toggle flop and CYC_END strobe.
//   Ports:
//     CLK12    in   12 MHz clock
//     RESET    in   synchronous active-high reset
//     run      in   1 while the motor is on; 0 clears counter and output
//     start    in   first clock of a run: output goes high, counter loads hp-1
//     hp       in   half-period to load (caller supplies the right tone)
//     cass_out out  square wave (registered)
//     cass_nxt out  value cass_out takes at the next edge
//     cyc_end  out  registered strobe, high for the clock after a full cycle
//     relatch  out  combinational: this edge closes a full cycle, so the
//                   caller should latch a new tone and present it on hp
// ---------------------------------------------------------------------------
module sorcerer_tone_gen (
    input  logic        CLK12,
    input  logic        RESET,
    input  logic        run,
    input  logic        start,
    input  logic [13:0] hp,
    output logic        cass_out,
    output logic        cass_nxt,
    output logic        cyc_end,
    output logic        relatch
);

    logic [13:0] cnt_q;
    logic        cass_q;
    logic        cend_q;
    logic        at_zero;

    assign at_zero = (cnt_q == 14'd0);

    // A full cycle ends when the low half expires: the output is about to
    // rise again. On a start the counter is also 0 and the output low, so
    // start must be excluded.
    assign relatch = run && !start && at_zero && !cass_q;

    always_comb begin
        cass_nxt = cass_q;
        if (!run) begin
            cass_nxt = 1'b0;
        end else if (start) begin
            cass_nxt = 1'b1;
        end else if (at_zero) begin
            cass_nxt = ~cass_q;
        end
    end

    always_ff @(posedge CLK12) begin
        if (RESET || !run) begin
            cnt_q  <= 14'd0;
            cass_q <= 1'b0;
            cend_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= hp - 14'd1;
            cass_q <= 1'b1;
            cend_q <= 1'b0;
        end else if (at_zero) begin
            cnt_q  <= hp - 14'd1;
            cass_q <= ~cass_q;
            cend_q <= ~cass_q;
        end else begin
            cnt_q  <= cnt_q - 14'd1;
            cend_q <= 1'b0;
        end
    end

    assign cass_out = cass_q;
    assign cyc_end  = cend_q;

endmodule

// File: rtl/sorcerer_cass_fsk.sv
// ---------------------------------------------------------------------------
// sorcerer_cass_fsk
//   Cassette-out FSK modulator (Sorcerer / Kansas City tones). Turns the
//   cassette UART serial line into a phase-continuous square wave and an
//   audio level; tone changes only take effect at full-cycle boundaries.
//   Ports:
//     CLK12  in   12 MHz system clock
//     RESET  in   synchronous active-high reset (wins over MOTOR)
//     bus    slave modport of sorcerer_cass_fsk_if
//              TX_BIT, BAUD_SEL, MOTOR in; CASS_OUT, AUDIO, CYC_END, STATE out
//   Parameters: HP_2400, HP_1200, HP_600 (half-periods, 2..16383), AMPL.
//   Build option: SORC_CASS_FILTER_EN -- when defined AUDIO is a one-pole
//   low-pass (1 MHz update) of the square wave instead of the square wave.
// ---------------------------------------------------------------------------
module sorcerer_cass_fsk
    import sorcerer_cass_pkg::*;
#(
    parameter logic [13:0] HP_2400 = HP_2400_DEF,
    parameter logic [13:0] HP_1200 = HP_1200_DEF,
    parameter logic [13:0] HP_600  = HP_600_DEF,
    parameter logic [13:0] AMPL    = AMPL_DEF
) (
    input  logic                 CLK12,
    input  logic                 RESET,
    sorcerer_cass_fsk_if.slave   bus
);

    cass_state_t state_q;
    logic        tone_bit_q;
    logic        tone_baud_q;

    logic        run;
    logic        start;
    logic        relatch;
    logic [13:0] hp;
    logic        cass_out;
    logic        cass_nxt;
    logic        cyc_end;
    logic [13:0] target;
    logic [13:0] audio_q;

    assign run   = bus.MOTOR;
    assign start = (state_q == OFF) && bus.MOTOR;

    // On a start or a cycle boundary the tone register is being loaded this
    // same edge, so the counter must take the half-period of the live inputs.
    always_comb begin
        hp = hp_sel(tone_baud_q, tone_bit_q, HP_2400, HP_1200, HP_600);
        if (start || relatch) begin
            hp = hp_sel(bus.BAUD_SEL, bus.TX_BIT, HP_2400, HP_1200, HP_600);
        end
    end

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            state_q     <= OFF;
            tone_bit_q  <= 1'b1;
            tone_baud_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (bus.MOTOR) begin
                        state_q     <= RUN;
                        tone_bit_q  <= bus.TX_BIT;
                        tone_baud_q <= bus.BAUD_SEL;
                    end
                end
                RUN: begin
                    if (!bus.MOTOR) begin
                        state_q <= OFF;
                    end else if (relatch) begin
                        tone_bit_q  <= bus.TX_BIT;
                        tone_baud_q <= bus.BAUD_SEL;
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    sorcerer_tone_gen u_tone_gen (
        .CLK12    (CLK12),
        .RESET    (RESET),
        .run      (run),
        .start    (start),
        .hp       (hp),
        .cass_out (cass_out),
        .cass_nxt (cass_nxt),
        .cyc_end  (cyc_end),
        .relatch  (relatch)
    );

    // Target level follows the value CASS_OUT takes at this edge, so the
    // unfiltered AUDIO register changes in the same cycle as CASS_OUT.
    assign target = cass_nxt ? AMPL : 14'd0;

`ifdef SORC_CASS_FILTER_EN
    logic [3:0]         div_q;
    logic               filt_en;
    logic signed [14:0] diff;
    logic signed [14:0] step;
    logic [13:0]        audio_nxt;

    // 1 MHz update in RUN. The divider idles at 0 in OFF, so the decay
    // toward 0 while OFF is stepped on every clock instead.
    assign filt_en   = (state_q == RUN) ? (div_q == 4'd11) : 1'b1;
    assign diff      = $signed({1'b0, target}) - $signed({1'b0, audio_q});
    assign step      = diff >>> 4;
    // Result always lies between audio_q and target, so 14-bit wrap-around
    // addition of the two's-complement step is exact.
    assign audio_nxt = audio_q + step[13:0];

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            div_q   <= 4'd0;
            audio_q <= 14'd0;
        end else begin
            if (state_q == OFF) begin
                div_q <= 4'd0;
            end else if (div_q == 4'd11) begin
                div_q <= 4'd0;
            end else begin
                div_q <= div_q + 4'd1;
            end
            if (filt_en) begin
                audio_q <= audio_nxt;
            end
        end
    end
`else
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            audio_q <= 14'd0;
        end else begin
            audio_q <= target;
        end
    end
`endif

    assign bus.CASS_OUT = cass_out;
    assign bus.CYC_END  = cyc_end;
    assign bus.AUDIO    = audio_q;
    assign bus.STATE    = state_q;

endmodule
